// File: rtl/load_store_unit.sv
// load_store_unit -- initiator side of a word-organised data memory port.
//
// Takes one RV32I load/store at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and runs it
// against a memory with combinational read and posedge write commit.
// Sub-word stores are done as read-modify-write through a merge buffer.
//
// Flow: IDLE -> READ -> RESP          loads
//       IDLE -> WRITE -> RESP         SW
//       IDLE -> READ -> WRITE -> RESP SB/SH
//       IDLE -> RESP                  illegal funct3 / misaligned
//
// Ports:
//   clock, reset         clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_store            1 = store, 0 = load
//   req_funct3           RV32I width/sign code
//   req_addr, req_wdata  byte address, store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load result, holds until next load
//   resp_error           illegal funct3 / misaligned, qualified by resp_valid
//   mem_read_enable, mem_write_enable, address (word index), write_data
//   read_data            combinational memory return
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/W accesses
// are reported as errors with no memory access; otherwise the low address
// bits are masked off so the access is forced aligned.
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic                      store_q;
  logic [2:0]                f3_q;
  logic [WORD_ADDR_BITS-1:0] idx_q;
  logic [31:0]               wdata_q;
  logic [1:0]                off_q;
  logic                      err_q;
  logic [31:0]               rdata_q;
  logic [31:0]               merge_q;

  logic        accept;
  logic        req_err;
  logic [1:0]  off_eff;
  logic        illegal;

  // Address bits above the word index wrap away by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:WORD_ADDR_BITS+2];

  assign accept  = req_valid && (state_q == S_IDLE);
  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_store && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err  = illegal || misalign;
  assign off_eff  = req_addr[1:0];
`else
  assign req_err = illegal;
  // Force alignment: halves drop addr[0], words drop addr[1:0].
  always_comb begin
    off_eff = req_addr[1:0];
    case (req_funct3[1:0])
      2'b01:   off_eff = {req_addr[1], 1'b0};
      2'b10:   off_eff = 2'b00;
      default: off_eff = req_addr[1:0];
    endcase
  end
`endif

  // Load extraction from the live memory return.
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  assign byte_v = read_data[{off_q, 3'b000} +: 8];
  assign half_v = read_data[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_ext = {{16{half_v[15]}}, half_v};
      3'b100:  load_ext = {24'h0, byte_v};
      3'b101:  load_ext = {16'h0, half_v};
      default: load_ext = read_data;
    endcase
  end

  // Old word with the store lane substituted.
  logic [31:0] wmerge;
  always_comb begin
    wmerge = merge_q;
    if (f3_q[1:0] == 2'b00)      wmerge[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
    else if (f3_q[1:0] == 2'b01) wmerge[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                                  state_d = S_RESP;
          else if (req_store && req_funct3[1:0] == 2'b10) state_d = S_WRITE;
          else                                          state_d = S_READ;
        end
      end
      S_READ:  state_d = store_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, load result and merge buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        idx_q   <= req_addr[WORD_ADDR_BITS+1:2];
        wdata_q <= req_wdata;
        off_q   <= off_eff;
        err_q   <= req_err;
      end
      if (state_q == S_READ) begin
        if (store_q) merge_q <= read_data;
        else         rdata_q <= load_ext;
      end
    end
  end

  assign resp_rdata = rdata_q;

  // Outputs decoded from state; strobes drop as soon as reset forces IDLE.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    address          = 32'h0;
    write_data       = 32'h0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        mem_read_enable = 1'b1;
        address         = {{(32-WORD_ADDR_BITS){1'b0}}, idx_q};
      end
      S_WRITE: begin
        mem_write_enable = 1'b1;
        address          = {{(32-WORD_ADDR_BITS){1'b0}}, idx_q};
        write_data       = (f3_q[1:0] == 2'b10) ? wdata_q : wmerge;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-organised data memory port: accepts one load or store at a time from the execute stage and produces the `mem_read_enable` / `mem_write_enable` / `address` / `write_data` sequence the memory expects. It reads the combinational `read_data` return. It implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:

- Byte/halfword extraction with sign or zero extension.
- Sub-word stores as read-modify-write.
- A one-cycle response pulse back to the pipeline.

## Interface

Parameters:
- `WORD_ADDR_BITS`, default 10: number of byte-address bits [WORD_ADDR_BITS+1:2] used as the memory word index (1024 words).

Ports:
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  unit is IDLE and can accept.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low byte/half used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; holds until next resp_valid.
- `resp_error`  out  1  misaligned or illegal funct3; valid with resp_valid.
- `mem_read_enable`  out  1  memory read strobe.
- `mem_write_enable`  out  1  memory write strobe; memory commits at posedge.
- `address`  out  32  word index, zero-extended from req_addr[WORD_ADDR_BITS+1:2].
- `write_data`  out  32  full word to write.
- `read_data`  in  32  combinational memory return, valid in the same cycle as mem_read_enable.

## Operation

- Accept occurs when `req_valid && req_ready` at posedge. The unit latches store, funct3, addr, wdata, byte offset = addr[1:0].
- FSM states and transitions:
  - IDLE.
  - READ: from IDLE on loads and on SB/SH.
  - WRITE: from IDLE on SW; from READ on SB/SH.
  - RESP: from READ on loads, from WRITE, or from IDLE on error.
  - RESP always returns to IDLE.
- READ:
  - Drives mem_read_enable=1.
  - Loads: extract the byte at offset*8 or the half at offset[1]*16 and sign-extend (000/001) or zero-extend (100/101); LW passes the word. Result is registered into resp_rdata.
  - SB/SH: register the old word into a merge buffer.
- WRITE:
  - Drives mem_write_enable=1.
  - write_data = wdata for SW. For SB/SH, write_data = merge buffer with wdata[7:0] / wdata[15:0] substituted at the offset lane.
- RESP drives resp_valid=1 for exactly one cycle. resp_error is valid with it.
- Error cases:
  - Misaligned: H with offset[0]=1; W with offset≠0.
  - Illegal funct3: 011, 110 or 111, and store with funct3 ≥ 100.
  - On error, go IDLE→RESP with resp_error=1, no memory strobe, and resp_rdata unchanged.
- address and write_data are decoded from latched state and are 0 in IDLE and RESP. Both enables are never high together.
- Address bits above WORD_ADDR_BITS+1 are ignored, so the index wraps modulo 2^WORD_ADDR_BITS words.

## Timing

- Reset values:
  - req_ready=1.
  - resp_valid=0, resp_error=0.
  - resp_rdata=0.
  - mem_read_enable=0, mem_write_enable=0.
  - address=0, write_data=0.
  - FSM=IDLE, merge buffer=0.
- Reset asserted mid-operation drops both strobes immediately and returns to IDLE. No response is issued. A WRITE cut by reset before its posedge is not committed.
- req_ready is high only in IDLE. Requests presented in other states are held off. resp_valid and req_ready are never both high.
- Latency is counted from the accept edge to the resp_valid cycle:
  - Load: READ (cycle 1), RESP (cycle 2).
  - SW: WRITE (cycle 1), RESP (cycle 2).
  - SB/SH: READ, WRITE, RESP (cycle 3).
  - Error: RESP (cycle 1).
- Back-to-back: the next accept can occur on the edge leaving RESP.
- A load issued immediately after a store to the same word sees the new data, because the store commits before RESP.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses produce resp_error=1 and no memory access, as above.
- `LSU_MISALIGN_TRAP_EN` not defined:
  - Misalignment is not checked.
  - addr[0] is ignored for halfword, and addr[1:0] is ignored for word (accesses are forced aligned).
  - resp_error flags illegal funct3 only.

## Test plan

- Reset:
  - Hold reset=0 → all outputs at reset values.
  - Release → req_ready=1.
- LW:
  - Preload word 5 = 0x8000_00FF; LW addr 0x14.
  - READ cycle shows address=5, mem_read_enable=1.
  - 2 cycles after accept, resp_rdata=0x8000_00FF, resp_error=0.
- Sub-word loads:
  - Word 2 = 0x1234_80F0.
  - LB addr 0x9 → 0xFFFF_FF80.
  - LBU addr 0x9 → 0x0000_0080.
  - LH addr 0xA → 0x0000_1234.
  - LHU addr 0x8 → 0x0000_80F0.
- SB read-modify-write:
  - Word 3 = 0xAABB_CCDD; SB addr 0xE, wdata 0x11.
  - Observe READ, then WRITE with write_data=0xAA11_CCDD; resp_valid on cycle 3.
  - Subsequent LW 0xC → 0xAA11_CCDD.
- Misaligned and wrap:
  - With macro, LW addr 0x6 → resp_valid, resp_error=1, no strobe.
  - Without macro, LW addr 0x6 reads word 1.
  - LW addr 0x1014 reads word 5.
- Reset mid-SH:
  - Assert reset during the WRITE cycle → strobe drops immediately, memory unchanged, no resp_valid.
  - After release, req_ready=1.
